// File: rtl/tsb_arb_pkg.sv
// Shared types, parameter limits and helpers for the tri-state bus arbiter.
package tsb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   localparam int MIN_N_REQ      = 2;
   localparam int MAX_N_REQ      = 16;
   localparam int MIN_TURNAROUND = 1;
   localparam int IDX_W          = 4;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N_REQ-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = 4'd0;
      for (int i = 0; i < MAX_N_REQ; i++) begin
         if (vec[i]) begin
            idx = idx | IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] win,
   output logic             any_req
);

   // Scan from rr_ptr upward modulo N_REQ and keep the first hit.
   always_comb begin
      logic found;
      int   pos;
      win   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = (int'(rr_ptr) + k) % N_REQ;
         if (!found && req[pos]) begin
            win[pos] = 1'b1;
            found    = 1'b1;
         end else begin
            found = found;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/tsb_arb_checker.sv
// Safety properties for the bus arbiter outputs: never two drivers, oe mirrors grant.
module tsb_arb_checker #(
   parameter int N_REQ = 4
) (
   input logic             clk,
   input logic             rst_n,
   input logic [N_REQ-1:0] grant,
   input logic [N_REQ-1:0] oe,
   input logic             bus_busy
);

   a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
   a_oe_onehot0:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(oe));
   a_oe_eq_grant:   assert property (@(posedge clk) disable iff (!rst_n) oe == grant);
   a_busy_matches:  assert property (@(posedge clk) disable iff (!rst_n) bus_busy == (|grant));

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with hold timeout and an all-off
// turnaround gap between owners so no two buffers ever drive together.
module tristate_bus_arbiter
   import tsb_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 16,
   parameter int ID_W       = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] oe,
   output logic             bus_busy,
   output logic [ID_W-1:0]  owner_id,
   output logic             preempt
);

   localparam int HW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TW         = $clog2(TURNAROUND + 1);
   localparam int HOLD_SAT_I = (MAX_HOLD > 0) ? MAX_HOLD : 1;
   localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_SAT_I);

   if (N_REQ < MIN_N_REQ || N_REQ > MAX_N_REQ || TURNAROUND < MIN_TURNAROUND || MAX_HOLD < 0) begin : g_bad_params
      $error("tristate_bus_arbiter: illegal parameter combination");
   end

   state_t           state_r, state_s;
   logic [N_REQ-1:0] grant_r, grant_s;
   logic [ID_W-1:0]  rr_ptr_r, rr_ptr_s;
   logic [HW-1:0]    hold_cnt_r, hold_cnt_s;
   logic [TW-1:0]    turn_cnt_r, turn_cnt_s;
   logic             preempt_r, preempt_s;
   logic [ID_W-1:0]  owner_id_r, owner_id_s;
   logic             bus_busy_r, bus_busy_s;

   logic [N_REQ-1:0] win_s;
   logic             any_req_s;
   logic [ID_W-1:0]  win_idx_s, next_ptr_s;
   logic             owner_req_s, other_req_s, hold_to_s, turn_done_s;

   rr_pick #(.N_REQ(N_REQ), .PTR_W(ID_W)) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr_r),
      .win     (win_s),
      .any_req (any_req_s)
   );

   assign win_idx_s   = ID_W'(onehot_to_idx(MAX_N_REQ'(win_s)));
   assign next_ptr_s  = (win_idx_s == ID_W'(N_REQ - 1)) ? ID_W'(0) : win_idx_s + ID_W'(1);
   assign owner_req_s = |(req & grant_r);
   assign other_req_s = |(req & ~grant_r);
   assign hold_to_s   = (MAX_HOLD != 0) && (hold_cnt_r >= HW'(MAX_HOLD - 1));
   assign turn_done_s = (turn_cnt_r >= TW'(TURNAROUND - 1));

   // Next-state, grant and counter decisions; owner drop beats timeout, so no preempt then.
   always_comb begin
      state_s    = state_r;
      grant_s    = grant_r;
      rr_ptr_s   = rr_ptr_r;
      hold_cnt_s = hold_cnt_r;
      turn_cnt_s = turn_cnt_r;
      preempt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_s    = ST_OWN;
               grant_s    = win_s;
               rr_ptr_s   = next_ptr_s;
               hold_cnt_s = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!owner_req_s) begin
               state_s    = ST_TURN;
               grant_s    = '0;
               turn_cnt_s = '0;
            end else if (hold_to_s && other_req_s) begin
               state_s    = ST_TURN;
               grant_s    = '0;
               turn_cnt_s = '0;
               preempt_s  = 1'b1;
            end else if (hold_cnt_r != HOLD_SAT) begin
               hold_cnt_s = hold_cnt_r + HW'(1);
            end else begin
               hold_cnt_s = hold_cnt_r;
            end
         end
         ST_TURN: begin
            if (!turn_done_s) begin
               turn_cnt_s = turn_cnt_r + TW'(1);
            end else if (any_req_s) begin
               state_s    = ST_OWN;
               grant_s    = win_s;
               rr_ptr_s   = next_ptr_s;
               hold_cnt_s = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = '0;
         end
      endcase
      owner_id_s = ID_W'(onehot_to_idx(MAX_N_REQ'(grant_s)));
      bus_busy_s = |grant_s;
   end

   // State and registered outputs; reset clears grant (hence oe) asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         grant_r    <= '0;
         rr_ptr_r   <= '0;
         hold_cnt_r <= '0;
         turn_cnt_r <= '0;
         preempt_r  <= 1'b0;
         owner_id_r <= '0;
         bus_busy_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         grant_r    <= grant_s;
         rr_ptr_r   <= rr_ptr_s;
         hold_cnt_r <= hold_cnt_s;
         turn_cnt_r <= turn_cnt_s;
         preempt_r  <= preempt_s;
         owner_id_r <= owner_id_s;
         bus_busy_r <= bus_busy_s;
      end
   end

   assign grant    = grant_r;
   assign oe       = grant_r;
   assign bus_busy = bus_busy_r;
   assign owner_id = owner_id_r;
   assign preempt  = preempt_r;

   tsb_arb_checker #(.N_REQ(N_REQ)) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .grant    (grant_r),
      .oe       (grant_r),
      .bus_busy (bus_busy_r)
   );

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Randomized and directed bench for tristate_bus_arbiter against an ownership-level model.
module tb_tristate_bus_arbiter;

   localparam int N   = 4;
   localparam int T   = 1;
   localparam int MH  = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   grant, oe;
   logic           bus_busy, preempt;
   logic [IDW-1:0] owner_id;

   int vectors     = 0;
   int miscompares = 0;

   // Model: who owns the bus, how long, remaining gap, and where the scan starts.
   int             m_owner, m_held, m_gap, m_ptr;
   logic [N-1:0]   exp_grant;
   logic [IDW-1:0] exp_id;
   logic           exp_busy, exp_pre;

   tristate_bus_arbiter #(.N_REQ(N), .TURNAROUND(T), .MAX_HOLD(MH), .ID_W(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .oe(oe),
      .bus_busy(bus_busy), .owner_id(owner_id), .preempt(preempt)
   );

   always #5 clk = ~clk;

   task automatic model_outputs();
      exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : 4'b0000;
      exp_id    = (m_owner >= 0) ? IDW'(m_owner) : 2'd0;
      exp_busy  = (m_owner >= 0);
   endtask

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; exp_pre = 1'b0;
      model_outputs();
   endtask

   task automatic model_step(input logic [N-1:0] r);
      logic do_arb;
      int   w;
      do_arb  = 1'b0;
      exp_pre = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1; m_gap = T;
         end else if (MH != 0 && m_held >= MH && (r & ~N'(1 << m_owner)) != 4'b0000) begin
            m_owner = -1; m_gap = T; exp_pre = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         do_arb = (m_gap == 0);
      end else begin
         do_arb = 1'b1;
      end
      if (do_arb) begin
         for (int k = 0; k < N; k++) begin
            w = (m_ptr + k) % N;
            if (m_owner < 0 && r[w]) begin
               m_owner = w; m_held = 1; m_ptr = (w + 1) % N;
            end
         end
      end
      model_outputs();
   endtask

   task automatic tick(input logic [N-1:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      #3;
      vectors++;
      if ({grant, oe, bus_busy, owner_id, preempt} !== 11'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got grant=%b oe=%b busy=%b id=%0d pre=%b, want all zero", grant, oe, bus_busy, owner_id, preempt);
      end
      do_reset();
      repeat (3) begin
         tick(4'b0010);
         vectors++;
         if ({grant, oe, bus_busy, owner_id, preempt} !== {exp_grant, exp_grant, exp_busy, exp_id, exp_pre}) begin
            miscompares++;
            $display("FAIL reset_own: got grant=%b oe=%b busy=%b id=%0d pre=%b, want grant=%b id=%0d pre=%b", grant, oe, bus_busy, owner_id, preempt, exp_grant, exp_id, exp_pre);
         end
      end
      rst_n = 1'b0;
      #2;
      vectors++;
      if (oe !== 4'b0000 || grant !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_async: got oe=%b grant=%b, want 0000", oe, grant);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         tick(4'b0000);
         vectors++;
         if ({grant, oe, bus_busy, owner_id, preempt} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got grant=%b oe=%b busy=%b id=%0d pre=%b, want all zero", grant, oe, bus_busy, owner_id, preempt);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      tick(4'b0100);
      vectors++;
      if (grant !== 4'b0100 || oe !== 4'b0100 || owner_id !== 2'd2 || bus_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_grant: got grant=%b oe=%b id=%0d busy=%b, want 0100/0100/2/1", grant, oe, owner_id, bus_busy);
      end
      for (int i = 0; i < 6; i++) begin
         tick((i < 3) ? 4'b0100 : 4'b0000);
         vectors++;
         if ({grant, oe, bus_busy, owner_id, preempt} !== {exp_grant, exp_grant, exp_busy, exp_id, exp_pre}) begin
            miscompares++;
            $display("FAIL single_seq: step %0d got grant=%b oe=%b busy=%b id=%0d pre=%b, want grant=%b id=%0d", i, grant, oe, bus_busy, owner_id, preempt, exp_grant, exp_id);
         end
      end
      vectors++;
      if (bus_busy !== 1'b0 || oe !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_idle: got busy=%b oe=%b, want 0/0000", bus_busy, oe);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] r, last_oe, prev_oe;
      logic [N-1:0] seen[$];
      logic [N-1:0] want[5];
      want    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      last_oe = 4'b0000;
      prev_oe = 4'b0000;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
         tick(r);
         vectors++;
         if ({grant, oe, bus_busy, owner_id, preempt} !== {exp_grant, exp_grant, exp_busy, exp_id, exp_pre}) begin
            miscompares++;
            $display("FAIL rr_model: cycle %0d got grant=%b pre=%b, want grant=%b pre=%b", c, grant, preempt, exp_grant, exp_pre);
         end
         if (prev_oe != 4'b0000 && oe != 4'b0000 && oe != prev_oe) begin
            miscompares++;
            $display("FAIL rr_gap: cycle %0d oe went %b -> %b without an idle cycle", c, prev_oe, oe);
         end
         if (oe != 4'b0000 && oe != last_oe) seen.push_back(oe);
         if (oe != 4'b0000) last_oe = oe;
         prev_oe = oe;
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (seen.size() <= i || seen[i] !== want[i]) begin
            miscompares++;
            $display("FAIL rr_order: grant %0d got %b, want %b", i, (seen.size() > i) ? seen[i] : 4'bxxxx, want[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [N-1:0] eg[11];
      logic         ep[11];
      eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         tick(4'b0011);
         vectors++;
         if (grant !== eg[i] || oe !== eg[i] || preempt !== ep[i] || grant !== exp_grant || preempt !== exp_pre) begin
            miscompares++;
            $display("FAIL timeout: step %0d got grant=%b oe=%b pre=%b, want grant=%b pre=%b", i, grant, oe, preempt, eg[i], ep[i]);
         end
      end
   endtask

   task automatic test_timeout_no_contention();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick(4'b1000);
         vectors++;
         if (grant !== 4'b1000 || preempt !== 1'b0 || owner_id !== 2'd3) begin
            miscompares++;
            $display("FAIL solo_hold: step %0d got grant=%b pre=%b id=%0d, want 1000/0/3", i, grant, preempt, owner_id);
         end
      end
      tick(4'b1001);
      vectors++;
      if (grant !== 4'b0000 || preempt !== 1'b1) begin
         miscompares++;
         $display("FAIL solo_preempt: got grant=%b pre=%b, want 0000/1", grant, preempt);
      end
      tick(4'b1001);
      vectors++;
      if (grant !== 4'b0001 || preempt !== 1'b0 || owner_id !== 2'd0) begin
         miscompares++;
         $display("FAIL solo_handover: got grant=%b pre=%b id=%0d, want 0001/0/0", grant, preempt, owner_id);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r, flip, prev_oe;
      r       = 4'b0000;
      prev_oe = 4'b0000;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         flip = 4'b0000;
         for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
         r = r ^ flip;
         tick(r);
         vectors++;
         if ({grant, oe, bus_busy, owner_id, preempt} !== {exp_grant, exp_grant, exp_busy, exp_id, exp_pre}) begin
            miscompares++;
            $display("FAIL random: cycle %0d req=%b got grant=%b oe=%b busy=%b id=%0d pre=%b, want grant=%b busy=%b id=%0d pre=%b", c, r, grant, oe, bus_busy, owner_id, preempt, exp_grant, exp_busy, exp_id, exp_pre);
         end
         if ($countones(oe) > 1 || (prev_oe != 4'b0000 && oe != 4'b0000 && oe != prev_oe)) begin
            miscompares++;
            $display("FAIL random_safety: cycle %0d oe %b -> %b", c, prev_oe, oe);
         end
         prev_oe = oe;
      end
   endtask

   initial begin
      req = 4'b0000;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_timeout_no_contention();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Arbitrates one shared tri-state bus among N_REQ drivers.
- Issues one-hot grants and per-driver output enables; each enable drives one tristate buffer's oe.
- Round-robin fairness, an optional maximum hold time, and a guaranteed all-disabled turnaround gap between owners, so two buffers never drive the bus in the same cycle.
- Sits between the requesting blocks and the tristate buffer bank on the shared bus.

Parameters:
- N_REQ, 4, number of requesters/drivers (2..16).
- TURNAROUND, 1, idle cycles with all oe low between owners (must be >= 1).
- MAX_HOLD, 16, max OWN cycles before forced release when another requester waits; 0 = unlimited.
- ID_W, $clog2(N_REQ), width of owner_id.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester bus request, level; held while the bus is needed.
- grant  output  N_REQ  one-hot ownership indication, registered.
- oe  output  N_REQ  one-hot tristate enable to each driver's buffer, registered.
- bus_busy  output  1  high while any grant is active.
- owner_id  output  ID_W  index of the current owner; 0 when none.
- preempt  output  1  one-cycle pulse when a grant is withdrawn by MAX_HOLD timeout.

Behaviour:
- Reset: asynchronous, active-low, clocked on the first edge of clk and rst_n. While rst_n is low, all outputs read 0: grant, oe, bus_busy, owner_id, preempt. Also state=IDLE, rr_ptr=0, hold_cnt=0, turn_cnt=0.
- Reset mid-operation: oe drops immediately (asynchronous) and the bus floats.
- Invariants: grant and oe are always zero or one-hot, and oe == grant in every cycle. Use $onehot0 assertions.
- States:
  - IDLE: no grants. If any req is sampled high at edge t, go to OWN; grant/oe are high from edge t, i.e. visible the cycle after req is seen (1-cycle latency).
  - OWN: hold_cnt increments every cycle and saturates.
    - Owner deasserts req → TURN; grant/oe low on the next edge.
    - MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and any other req high → TURN with a preempt pulse on the same edge that drops grant.
    - Timeout reached with no other requester → keep grant and hold hold_cnt saturated. Preemption happens as soon as another req rises.
  - TURN: all oe low for exactly TURNAROUND cycles (turn_cnt). Then go to OWN with a new winner if any req is high, else IDLE. Requests arriving during TURN are held off until TURN ends.
- Arbitration:
  - Winner is the first requester with req high scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - On each grant, rr_ptr becomes winner+1 (wrap N_REQ-1 → 0).
  - A released owner that re-requests immediately gets lowest priority against other pending requests. It wins again after TURN if it is the only requester.
- Simultaneous events:
  - Owner drop and timeout in the same cycle: treat as a normal release, no preempt.
  - req from the owner rising again in its final TURN cycle: eligible for arbitration.
- Requesters must not drive the bus unless their oe is high. The arbiter does not observe bus data.
- hold_cnt width is $clog2(MAX_HOLD+1). It resets to 0 on every new grant.

Decomposition:
- Package tsb_arb_pkg holds:
  - state enum {ST_IDLE, ST_OWN, ST_TURN};
  - parameter-check constants;
  - function onehot_to_idx.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and rr_ptr; outputs are one-hot win and any_req. Reusable for other shared-resource arbiters.
- The FSM, counters and output registers live in tristate_bus_arbiter.

Test Plan (N_REQ=4, TURNAROUND=1, MAX_HOLD=4):
1. Reset: assert rst_n=0 mid-OWN with oe=0010 → oe/grant drop to 0000 asynchronously; after release with req=0000 → IDLE, bus_busy=0.
2. Single requester: req=0100 at edge 0 → grant=oe=0100, owner_id=2 from edge 0 through release. req→0 → oe=0000 for 1 cycle, then IDLE.
3. Round-robin: req=1111 held, owners release after 2 cycles each → grant order 0001,0010,0100,1000,0001, each separated by one all-zero oe cycle.
4. Timeout preemption: req=0011 held constantly → req0 owns 4 cycles, preempt pulses once, 1 turnaround cycle, req1 owns 4 cycles, preempt, back to req0.
5. Timeout without contention: only req=1000 held for 20 cycles → grant stays 1000, preempt never asserts. Raise req0 → preempt on the next edge, then grant 0001 after turnaround.
6. Contention safety: random req for 10k cycles → oe never has more than one bit set, oe==grant, and every owner change includes ≥1 cycle with oe=0000.
